m_or_carry_acc: RTL and testbench
=================================

Name: m_or_carry_acc

Overview:
- Registered, carry-recovering stochastic OR-adder for the neuron summation path.
- Combines N unipolar bitstreams into one output stream, like a cascaded OR tree.
- A plain OR loses a count whenever two or more inputs are high in the same cycle. This block counts those excess ones in an accumulator and re-emits them in later cycles where no input is high, which reduces the OR saturation bias.
- Also exports the registered per-cycle popcount and carry flags for downstream saturation monitoring.

Parameters:
- N, 3: number of input streams, N >= 1.
- CW, 4: accumulator width in bits; ACC_MAX = 2^CW - 1.
- MODE, 1: 0 = plain registered OR (accumulator held at 0); 1 = carry recovery.
- NB (localparam), clog2(N+1): popcount width.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- EN  input  1  stream enable; sampled on CLK.
- CLR  input  1  synchronous clear of the accumulator and SAT; priority over EN.
- IN  input  N  input bitstreams, one bit per stream per cycle.
- OUT  output  1  registered output stream bit.
- CARRY0  output  1  registered; 1 when popcount(IN) > 1.
- CARRY1  output  1  registered; 1 when popcount(IN) > 2.
- N_HIGH  output  NB  registered popcount of IN.
- ACC  output  CW  current accumulator value.
- SAT  output  1  sticky flag: the accumulator clipped at ACC_MAX since the last CLR or RESET.

Behaviour:
- Reset: RESET high forces OUT, CARRY0, CARRY1, N_HIGH, ACC and SAT to 0 immediately, regardless of CLK. Reset mid-stream discards pending counts. The first update after deassertion is the first rising edge with RESET low.
- Latency: every output reflects the inputs sampled at the previous rising edge (1 cycle).
- Per edge, let p = popcount(IN). Compute the sum s = ACC + p at width CW+NB+1 (no internal overflow).
- EN=0, CLR=0:
  - OUT, CARRY0, CARRY1 and N_HIGH go to 0.
  - ACC and SAT hold.
- EN=1, CLR=0, MODE=1:
  - OUT <= (s > 0).
  - ACC <= min(s - OUT_next, ACC_MAX), so at most one count leaves per cycle.
  - SAT <= SAT | (s - OUT_next > ACC_MAX).
- EN=1, CLR=0, MODE=0:
  - OUT <= (p > 0).
  - ACC stays 0; SAT stays 0.
- All EN=1 cases: N_HIGH <= p, CARRY0 <= (p > 1), CARRY1 <= (p > 2).
- CLR=1:
  - ACC <= 0 and SAT <= 0; pending counts are discarded.
  - If EN=1: OUT <= (p > 0) and N_HIGH/CARRY* update as normal.
  - If EN=0: OUT and N_HIGH/CARRY* go to 0.
- N=1: CARRY0 and CARRY1 are tied to 0. ACC stays 0, because p - OUT is never positive.
- N=2: CARRY1 is tied to 0.
- Boundaries:
  - ACC never wraps; it clips at ACC_MAX.
  - ACC=0 with p=0 gives OUT=0 and no underflow.
  - ACC=ACC_MAX with p=1 holds ACC_MAX and gives OUT=1 with no SAT change.
- Conservation (MODE=1, no clipping, no CLR): the sum of OUT over a run plus the final ACC equals the sum of p over the run.

Test Plan (N=3, CW=4 unless stated):
1. RESET pulse while ACC=5 and IN=111, asserted between edges -> all outputs read 0 before the next edge and stay 0 while RESET is high.
2. MODE=1, EN=1; IN=111 for one cycle, then IN=000 for 3 cycles -> OUT 1,1,1,0; ACC 2,1,0,0; first cycle N_HIGH=3, CARRY0=1, CARRY1=1; later cycles N_HIGH=0, CARRY0=0, CARRY1=0.
3. MODE=1, IN=111 held for 10 cycles -> ACC 2,4,6,…,14, then 15 on cycle 8 with SAT=1, and 15 on cycles 9-10; OUT=1 throughout. SAT stays 1 after IN=000 until CLR.
4. MODE=0, IN=111 then 000 -> OUT 1,0; CARRY0 1,0; ACC 0 throughout; SAT 0.
5. MODE=1, ACC=4, EN=0, IN=111 for 3 cycles -> OUT=0, N_HIGH=0, CARRY0/1=0, ACC held at 4. Then EN=1, IN=000 -> OUT 1 for 4 cycles, ACC 3,2,1,0.
6. MODE=1, ACC=6, SAT=1; CLR=1, EN=1, IN=010 -> next edge OUT=1, ACC=0, SAT=0, N_HIGH=1. With random IN over 1000 cycles and no clipping, the conservation identity holds.

Source files
------------

// File: rtl/m_or_carry_acc.sv
// Registered stochastic OR-adder with carry recovery.
// Multiple high inputs in one cycle are accumulated as excess counts. Those counts are
// re-emitted in later cycles where no input is high, which reduces the OR saturation bias.
module m_or_carry_acc #(
  parameter int unsigned N    = 3,
  parameter int unsigned CW   = 4,
  parameter int unsigned MODE = 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         EN,
  input  logic                         CLR,
  input  logic [N-1:0]                 IN,
  output logic                         OUT,
  output logic                         CARRY0,
  output logic                         CARRY1,
  output logic [$clog2(N+1)-1:0]       N_HIGH,
  output logic [CW-1:0]                ACC,
  output logic                         SAT
);

  localparam int unsigned NB = $clog2(N + 1);
  // Wide enough that ACC + popcount can never overflow.
  localparam int unsigned SW = CW + NB + 1;
  localparam logic [CW-1:0] AccMax = '1;

  logic [NB-1:0] pop_c;
  logic [SW-1:0] sum_c;
  logic [SW-1:0] rem_c;
  logic          rec_out_c;
  logic          clip_c;

  logic          out_q, out_d;
  logic          carry0_q, carry0_d;
  logic          carry1_q, carry1_d;
  logic [NB-1:0] n_high_q, n_high_d;
  logic [CW-1:0] acc_q, acc_d;
  logic          sat_q, sat_d;

  // Popcount of the input streams and the carry-recovery arithmetic.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      pop_c = pop_c + NB'(IN[i]);
    end
    sum_c     = SW'(acc_q) + SW'(pop_c);
    rec_out_c = |sum_c;
    // At most one count leaves per cycle; the rest stays in the accumulator.
    rem_c     = sum_c - SW'(rec_out_c);
    clip_c    = rem_c > SW'(AccMax);
  end

  // Next-state selection: CLR beats EN, and EN=0 zeroes the stream outputs but holds the state.
  always_comb begin
    out_d    = 1'b0;
    carry0_d = 1'b0;
    carry1_d = 1'b0;
    n_high_d = '0;
    acc_d    = acc_q;
    sat_d    = sat_q;
    if (EN) begin
      n_high_d = pop_c;
      // Comparisons in 32 bits so that narrow popcounts (N=1) do not truncate the constants.
      carry0_d = (N > 1) && (32'(pop_c) > 32'd1);
      carry1_d = (N > 2) && (32'(pop_c) > 32'd2);
    end
    if (CLR) begin
      acc_d = '0;
      sat_d = 1'b0;
      out_d = EN && (pop_c != '0);
    end else if (EN) begin
      if (MODE == 1) begin
        out_d = rec_out_c;
        acc_d = clip_c ? AccMax : rem_c[CW-1:0];
        sat_d = sat_q | clip_c;
      end else begin
        out_d = pop_c != '0;
        acc_d = '0;
        sat_d = 1'b0;
      end
    end
  end

  // State and registered outputs, cleared asynchronously by RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_q    <= 1'b0;
      carry0_q <= 1'b0;
      carry1_q <= 1'b0;
      n_high_q <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      carry0_q <= carry0_d;
      carry1_q <= carry1_d;
      n_high_q <= n_high_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
    end
  end

  assign OUT    = out_q;
  assign CARRY0 = carry0_q;
  assign CARRY1 = carry1_q;
  assign N_HIGH = n_high_q;
  assign ACC    = acc_q;
  assign SAT    = sat_q;

endmodule

// File: tb/tb_m_or_carry_acc.sv
// Scoreboard bench for m_or_carry_acc (N=3, CW=4) with carry-recovery and plain-OR instances.
module tb_m_or_carry_acc;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       EN = 1'b0;
  logic       CLR = 1'b0;
  logic [2:0] IN = 3'b000;

  logic       out1, c0_1, c1_1, sat1;
  logic [1:0] nh1;
  logic [3:0] acc1;
  logic       out0, c0_0, c1_0, sat0;
  logic [1:0] nh0;
  logic [3:0] acc0;

  m_or_carry_acc #(.N(3), .CW(4), .MODE(1)) u_dut_rec (
    .CLK(CLK), .RESET(RESET), .EN(EN), .CLR(CLR), .IN(IN),
    .OUT(out1), .CARRY0(c0_1), .CARRY1(c1_1), .N_HIGH(nh1), .ACC(acc1), .SAT(sat1)
  );

  m_or_carry_acc #(.N(3), .CW(4), .MODE(0)) u_dut_or (
    .CLK(CLK), .RESET(RESET), .EN(EN), .CLR(CLR), .IN(IN),
    .OUT(out0), .CARRY0(c0_0), .CARRY1(c1_0), .N_HIGH(nh0), .ACC(acc0), .SAT(sat0)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int out1;
    int c0;
    int c1;
    int nh;
    int acc;
    int sat;
    int out0;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   m_acc = 0;
  int   m_sat = 0;
  int   sum_p = 0;
  int   sum_out = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Pop the oldest expectation and compare it against both instances.
  task automatic compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check("out", int'(out1), e.out1);
    check("carry0", int'(c0_1), e.c0);
    check("carry1", int'(c1_1), e.c1);
    check("n_high", int'(nh1), e.nh);
    check("acc", int'(acc1), e.acc);
    check("sat", int'(sat1), e.sat);
    check("or_out", int'(out0), e.out0);
    check("or_carry0", int'(c0_0), e.c0);
    check("or_acc", int'(acc0), 0);
    check("or_sat", int'(sat0), 0);
    sum_out += int'(out1);
  endtask

  // Drive one cycle, model the edge, queue the expectation and check it 1 time unit later.
  task automatic step(input logic en, input logic clr, input logic [2:0] in_v);
    exp_t e;
    int p, s, o, r;
    EN = en;
    CLR = clr;
    IN = in_v;
    @(posedge CLK);
    p = $countones(in_v);
    e.nh = en ? p : 0;
    e.c0 = (en && p > 1) ? 1 : 0;
    e.c1 = (en && p > 2) ? 1 : 0;
    e.out0 = (en && p > 0) ? 1 : 0;
    if (clr) begin
      m_acc = 0;
      m_sat = 0;
      e.out1 = (en && p > 0) ? 1 : 0;
    end else if (en) begin
      s = m_acc + p;
      o = (s > 0) ? 1 : 0;
      r = s - o;
      if (r > 15) begin
        m_acc = 15;
        m_sat = 1;
      end else begin
        m_acc = r;
      end
      e.out1 = o;
    end else begin
      e.out1 = 0;
    end
    e.acc = m_acc;
    e.sat = m_sat;
    sb_q.push_back(e);
    #1;
    compare();
  endtask

  initial begin
    logic [2:0] rv;
    #12;
    check("reset_out", int'(out1), 0);
    check("reset_acc", int'(acc1), 0);
    RESET = 1'b0;

    // Build ACC=5, then reset between edges.
    step(1'b1, 1'b0, 3'b111);
    step(1'b1, 1'b0, 3'b111);
    step(1'b1, 1'b0, 3'b011);
    check("pre_reset_acc", int'(acc1), 5);
    #2;
    RESET = 1'b1;
    #1;
    check("rst_out", int'(out1), 0);
    check("rst_carry0", int'(c0_1), 0);
    check("rst_carry1", int'(c1_1), 0);
    check("rst_n_high", int'(nh1), 0);
    check("rst_acc", int'(acc1), 0);
    check("rst_sat", int'(sat1), 0);
    @(posedge CLK);
    #1;
    check("rst_hold_acc", int'(acc1), 0);
    check("rst_hold_out", int'(out1), 0);
    RESET = 1'b0;
    m_acc = 0;
    m_sat = 0;

    // One burst of three, then drain.
    step(1'b1, 1'b0, 3'b111);
    check("burst_acc", int'(acc1), 2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'b000);
    check("drain_acc", int'(acc1), 0);
    check("drain_out", int'(out1), 0);

    // Saturation: ten cycles of 111.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 3'b111);
    check("sat_acc", int'(acc1), 15);
    check("sat_flag", int'(sat1), 1);

    // Drain to ACC=6 with SAT still set.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 3'b000);
    check("sat_sticky", int'(sat1), 1);
    check("pre_clr_acc", int'(acc1), 6);

    // CLR with EN and one input high.
    step(1'b1, 1'b1, 3'b010);
    check("clr_out", int'(out1), 1);
    check("clr_acc", int'(acc1), 0);
    check("clr_sat", int'(sat1), 0);
    check("clr_n_high", int'(nh1), 1);

    // Enable gating with ACC=4.
    step(1'b1, 1'b0, 3'b111);
    step(1'b1, 1'b0, 3'b111);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b111);
    check("gated_acc", int'(acc1), 4);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3'b000);
    check("gated_drain", int'(acc1), 0);

    // CLR without EN.
    step(1'b1, 1'b0, 3'b111);
    step(1'b0, 1'b1, 3'b111);

    // ACC at ACC_MAX with one input high holds ACC_MAX without raising SAT.
    step(1'b1, 1'b1, 3'b000);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 3'b111);
    step(1'b1, 1'b0, 3'b011);
    check("max_acc", int'(acc1), 15);
    check("max_sat", int'(sat1), 0);
    step(1'b1, 1'b0, 3'b100);
    check("max_hold_acc", int'(acc1), 15);
    check("max_hold_sat", int'(sat1), 0);

    // Random sparse streams; conservation from a cleared accumulator.
    step(1'b1, 1'b1, 3'b000);
    sum_p = 0;
    sum_out = 0;
    for (int i = 0; i < 1000; i++) begin
      rv[0] = ($urandom_range(4) == 0);
      rv[1] = ($urandom_range(4) == 0);
      rv[2] = ($urandom_range(4) == 0);
      sum_p += $countones(rv);
      step(1'b1, 1'b0, rv);
    end
    check("no_clip", int'(sat1), 0);
    check("conservation", sum_out + int'(acc1), sum_p);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
